// File: rtl/spi_slave_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_core_if
//  Purpose  : Bundles the SPI pins and the fabric-side valid/ready TX/RX
//             handshakes of spi_slave_core. The slave modport is the core's
//             view. The master modport is the view of the SPI master and the
//             fabric logic around it.
//  Revision : 1.0  initial release
// ============================================================================
interface spi_slave_core_if #(
    parameter int DATA_W = 8
) ();
    logic              sck;
    logic              ssel_n;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_overrun;
    logic              tx_underrun;
    logic              busy;

    modport slave (
        input  sck, ssel_n, mosi, tx_data, tx_valid, rx_ready,
        output miso, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, busy
    );

    modport master (
        output sck, ssel_n, mosi, tx_data, tx_valid, rx_ready,
        input  miso, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_core.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_core
//  Purpose  : SPI slave with configurable word width, CPOL/CPHA mode and bit
//             order. It has one-entry TX buffering and a valid/ready RX output.
//             It reports RX overrun and TX underrun.
//             SPI_SLAVE_ECHO_EN (optional define): on TX underrun, reload the
//             last received word instead of IDLE_WORD.
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave_core #(
    parameter int                DATA_W      = 8,
    parameter int                CPOL        = 0,
    parameter int                CPHA        = 0,
    parameter int                MSB_FIRST   = 1,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD   = '0
) (
    input wire logic        clk,
    input wire logic        rst_n,
    spi_slave_core_if.slave bus
);
    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic             SCK_IDLE = (CPOL != 0);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;
    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, ssel_sync, mosi_sync;
    logic                   sck_prev, ssel_prev;
    logic                   sck_s, ssel_s, mosi_s;
    logic                   sck_edge, sample_edge, shift_edge, ssel_fall, ssel_rise;

    logic [CNT_W-1:0]  bitcnt;
    logic [DATA_W-1:0] tx_shift, tx_buf, tx_shifted, fallback_word;
    logic [DATA_W-1:0] rx_shift, rx_shifted, rx_word;
    logic              tx_full, tx_accept, tx_bit, underrun_pulse;
    logic              word_done, rx_full, overrun_pulse;
    logic              do_load, do_shift, do_sample;

    // Bring the SPI pins into the clk domain and keep one extra flop for edge detection.
    // ssel_n resets to the selected level. A slave select that is held low through
    // reset therefore does not look like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
            ssel_sync <= '0;
            mosi_sync <= '0;
            sck_prev  <= SCK_IDLE;
            ssel_prev <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], bus.ssel_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sck_prev  <= sck_s;
            ssel_prev <= ssel_s;
        end
    end

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign ssel_s    = ssel_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sck_edge  = sck_s ^ sck_prev;
    assign ssel_fall = ssel_prev & ~ssel_s;
    assign ssel_rise = ~ssel_prev & ssel_s;
    // A leading edge moves sck away from its idle level. A trailing edge returns it.
    assign sample_edge = sck_edge & ((CPHA != 0) ? (sck_s == SCK_IDLE) : (sck_s != SCK_IDLE));
    assign shift_edge  = sck_edge & ~sample_edge;

    // Bit-order dependent taps for the TX and RX shift registers.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign tx_bit     = tx_shift[DATA_W-1];
            assign tx_shifted = {tx_shift[DATA_W-2:0], 1'b0};
            assign rx_shifted = {rx_shift[DATA_W-2:0], mosi_s};
        end else begin : g_lsb_first
            assign tx_bit     = tx_shift[0];
            assign tx_shifted = {1'b0, tx_shift[DATA_W-1:1]};
            assign rx_shifted = {mosi_s, rx_shift[DATA_W-1:1]};
        end
    endgenerate

`ifdef SPI_SLAVE_ECHO_EN
    assign fallback_word = rx_word;
`else
    assign fallback_word = IDLE_WORD;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next state and per-cycle datapath strobes. A deselect wins over any sck edge
    // in the same cycle. A shift edge at bitcnt==0 starts a new word, so it loads
    // instead of shifting.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        do_sample  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ssel_fall) begin
                    state_next = ST_ACTIVE;
                    do_load    = (CPHA == 0);
                end
            end
            ST_ACTIVE: begin
                if (ssel_rise) begin
                    state_next = ST_IDLE;
                end else begin
                    do_sample = sample_edge;
                    if (shift_edge) begin
                        if (bitcnt == '0) do_load  = 1'b1;
                        else              do_shift = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign tx_accept = bus.tx_valid & ~tx_full;

    // TX holding buffer and shift register. A word accepted in a load cycle with an
    // empty buffer is not bypassed: the fallback word loads and the new word is buffered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_shift       <= '0;
            tx_buf         <= '0;
            tx_full        <= 1'b0;
            underrun_pulse <= 1'b0;
        end else begin
            underrun_pulse <= 1'b0;
            if (do_load) begin
                if (tx_full) begin
                    tx_shift <= tx_buf;
                    tx_full  <= 1'b0;
                end else begin
                    tx_shift       <= fallback_word;
                    underrun_pulse <= 1'b1;
                end
            end else if (do_shift) begin
                tx_shift <= tx_shifted;
            end
            if (tx_accept) begin
                tx_buf  <= bus.tx_data;
                tx_full <= 1'b1;
            end
        end
    end

    // RX sampling and bit counter. A deselect drops the partial word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitcnt    <= '0;
            rx_shift  <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (state == ST_ACTIVE && ssel_rise) begin
                bitcnt <= '0;
            end else if (do_sample) begin
                rx_shift <= rx_shifted;
                if (bitcnt == LAST_BIT) begin
                    bitcnt    <= '0;
                    word_done <= 1'b1;
                end else begin
                    bitcnt <= bitcnt + 1'b1;
                end
            end
        end
    end

    // RX output register and handshake. A completion in the same cycle as a handshake
    // replaces the consumed word and is not an overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_word       <= '0;
            rx_full       <= 1'b0;
            overrun_pulse <= 1'b0;
        end else begin
            overrun_pulse <= 1'b0;
            if (word_done) begin
                rx_word       <= rx_shift;
                rx_full       <= 1'b1;
                overrun_pulse <= rx_full & ~bus.rx_ready;
            end else if (rx_full && bus.rx_ready) begin
                rx_full <= 1'b0;
            end
        end
    end

    assign bus.miso        = (state == ST_ACTIVE) ? tx_bit : 1'b0;
    assign bus.tx_ready    = ~tx_full;
    assign bus.rx_data     = rx_word;
    assign bus.rx_valid    = rx_full;
    assign bus.rx_overrun  = overrun_pulse;
    assign bus.tx_underrun = underrun_pulse;
    assign bus.busy        = (state == ST_ACTIVE);
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_core
//  Purpose  : Scoreboard bench for spi_slave_core with three instances:
//             a = mode 0, 8 bit, MSB first; b = mode 3, 8 bit, MSB first;
//             c = mode 0, 16 bit, LSB first. A single bit-banged master is
//             routed to one instance at a time.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_core;
    localparam int H = 8;   // sck half period in clk cycles

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic m_sck = 1'b0, m_ssel_n = 1'b1, m_mosi = 1'b0;
    int   sel = 0;

    logic [31:0] exp_a[$], exp_b[$], exp_c[$];
    int ov[3], un[3];

    spi_slave_core_if #(.DATA_W(8))  bus_a ();
    spi_slave_core_if #(.DATA_W(8))  bus_b ();
    spi_slave_core_if #(.DATA_W(16)) bus_c ();

    assign bus_a.sck    = (sel == 0) ? m_sck    : 1'b0;
    assign bus_a.ssel_n = (sel == 0) ? m_ssel_n : 1'b1;
    assign bus_a.mosi   = (sel == 0) ? m_mosi   : 1'b0;
    assign bus_b.sck    = (sel == 1) ? m_sck    : 1'b1;
    assign bus_b.ssel_n = (sel == 1) ? m_ssel_n : 1'b1;
    assign bus_b.mosi   = (sel == 1) ? m_mosi   : 1'b0;
    assign bus_c.sck    = (sel == 2) ? m_sck    : 1'b0;
    assign bus_c.ssel_n = (sel == 2) ? m_ssel_n : 1'b1;
    assign bus_c.mosi   = (sel == 2) ? m_mosi   : 1'b0;

    spi_slave_core #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    spi_slave_core #(.DATA_W(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
    spi_slave_core #(.DATA_W(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic cpol_of(input int k); return (k == 1); endfunction
    function automatic logic cpha_of(input int k); return (k == 1); endfunction
    function automatic logic msb_of(input int k);  return (k != 2); endfunction

    function automatic logic miso_of(input int k);
        return (k == 0) ? bus_a.miso : (k == 1) ? bus_b.miso : bus_c.miso;
    endfunction
    function automatic logic busy_of(input int k);
        return (k == 0) ? bus_a.busy : (k == 1) ? bus_b.busy : bus_c.busy;
    endfunction
    function automatic logic tx_ready_of(input int k);
        return (k == 0) ? bus_a.tx_ready : (k == 1) ? bus_b.tx_ready : bus_c.tx_ready;
    endfunction

    // Scoreboard monitors: one pop per accepted RX word.
    always @(negedge clk) begin
        if (bus_a.rx_valid && bus_a.rx_ready) begin
            if (exp_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx_a_unexpected: got 0x%0h expected none", bus_a.rx_data);
            end else check("rx_a", 32'(bus_a.rx_data), exp_a.pop_front());
        end
        if (bus_b.rx_valid && bus_b.rx_ready) begin
            if (exp_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx_b_unexpected: got 0x%0h expected none", bus_b.rx_data);
            end else check("rx_b", 32'(bus_b.rx_data), exp_b.pop_front());
        end
        if (bus_c.rx_valid && bus_c.rx_ready) begin
            if (exp_c.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx_c_unexpected: got 0x%0h expected none", bus_c.rx_data);
            end else check("rx_c", 32'(bus_c.rx_data), exp_c.pop_front());
        end
    end

    // Pulse counters for overrun/underrun.
    always @(negedge clk) begin
        if (bus_a.rx_overrun)  ov[0]++;
        if (bus_b.rx_overrun)  ov[1]++;
        if (bus_c.rx_overrun)  ov[2]++;
        if (bus_a.tx_underrun) un[0]++;
        if (bus_b.tx_underrun) un[1]++;
        if (bus_c.tx_underrun) un[2]++;
    end

    task automatic hwait;
        repeat (H) @(posedge clk);
        #2;
    endtask

    task automatic push_tx(input int k, input logic [31:0] w);
        int t = 0;
        while (!tx_ready_of(k) && t < 2000) begin
            @(posedge clk); #2;
            t++;
        end
        if (t >= 2000) check("tx_ready_wait", 32'(tx_ready_of(k)), 32'd1);
        case (k)
            0: begin bus_a.tx_data = w[7:0];  bus_a.tx_valid = 1'b1; end
            1: begin bus_b.tx_data = w[7:0];  bus_b.tx_valid = 1'b1; end
            default: begin bus_c.tx_data = w[15:0]; bus_c.tx_valid = 1'b1; end
        endcase
        @(posedge clk); #2;
        bus_a.tx_valid = 1'b0;
        bus_b.tx_valid = 1'b0;
        bus_c.tx_valid = 1'b0;
    endtask

    task automatic spi_begin(input int k);
        m_sck  = cpol_of(k);
        m_mosi = 1'b0;
        sel    = k;
        hwait();
        m_ssel_n = 1'b0;
        hwait();
        check("busy_on", 32'(busy_of(k)), 32'd1);
    endtask

    task automatic spi_end(input int k);
        hwait();
        m_ssel_n = 1'b1;
        hwait();
        check("busy_off", 32'(busy_of(k)), 32'd0);
    endtask

    task automatic sck_bit(input int k, input logic b, output logic mi);
        if (!cpha_of(k)) begin
            m_mosi = b;
            hwait();
            mi    = miso_of(k);
            m_sck = ~cpol_of(k);
            hwait();
            m_sck = cpol_of(k);
        end else begin
            m_sck  = ~cpol_of(k);
            m_mosi = b;
            hwait();
            mi    = miso_of(k);
            m_sck = cpol_of(k);
            hwait();
        end
    endtask

    task automatic spi_word(input int k, input logic [31:0] w, input int nbits,
                            input logic [31:0] exp_miso, input bit chk);
        logic [31:0] got = '0;
        logic        mi;
        for (int i = 0; i < nbits; i++) begin
            int idx = msb_of(k) ? (nbits - 1 - i) : i;
            sck_bit(k, w[idx], mi);
            got[idx] = mi;
        end
        if (chk) check("miso_word", got, exp_miso);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int un0, ov0;
        bus_a.tx_valid = 1'b0; bus_a.tx_data = '0; bus_a.rx_ready = 1'b1;
        bus_b.tx_valid = 1'b0; bus_b.tx_data = '0; bus_b.rx_ready = 1'b1;
        bus_c.tx_valid = 1'b0; bus_c.tx_data = '0; bus_c.rx_ready = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset state
        check("rst_miso",     32'(bus_a.miso), 32'd0);
        check("rst_tx_ready", 32'(bus_a.tx_ready), 32'd1);
        check("rst_rx_data",  32'(bus_a.rx_data), 32'd0);
        check("rst_rx_valid", 32'(bus_a.rx_valid), 32'd0);
        check("rst_busy",     32'(bus_a.busy), 32'd0);
        check("rst_ovr_und",  32'({bus_a.rx_overrun, bus_a.tx_underrun}), 32'd0);

        // 1: mode 0, preloaded 0xA5, master sends 0x3C
        push_tx(0, 32'hA5);
        check("t1_tx_ready_full", 32'(bus_a.tx_ready), 32'd0);
        exp_a.push_back(32'h3C);
        spi_begin(0);
        check("t1_tx_ready_loaded", 32'(bus_a.tx_ready), 32'd1);
        check("t1_first_miso", 32'(bus_a.miso), 32'd1);
        spi_word(0, 32'h3C, 8, 32'hA5, 1'b1);
        spi_end(0);

        // 2: mode 3, two back-to-back words with TX refilled in between
        un0 = un[1]; ov0 = ov[1];
        exp_b.push_back(32'h81);
        exp_b.push_back(32'h7E);
        fork
            begin
                push_tx(1, 32'h12);
                push_tx(1, 32'h34);
            end
            begin
                spi_begin(1);
                spi_word(1, 32'h81, 8, 32'h12, 1'b1);
                spi_word(1, 32'h7E, 8, 32'h34, 1'b1);
                spi_end(1);
            end
        join
        check("t2_underruns", 32'(un[1] - un0), 32'd0);
        check("t2_overruns",  32'(ov[1] - ov0), 32'd0);

        // 3: empty TX buffer -> fallback word and one underrun per word
        un0 = un[1];
        exp_b.push_back(32'h55);
        spi_begin(1);
`ifdef SPI_SLAVE_ECHO_EN
        spi_word(1, 32'h55, 8, 32'h7E, 1'b1);
`else
        spi_word(1, 32'h55, 8, 32'h00, 1'b1);
`endif
        spi_end(1);
        check("t3_underrun_1", 32'(un[1] - un0), 32'd1);
        exp_b.push_back(32'hAA);
        spi_begin(1);
`ifdef SPI_SLAVE_ECHO_EN
        spi_word(1, 32'hAA, 8, 32'h55, 1'b1);
`else
        spi_word(1, 32'hAA, 8, 32'h00, 1'b1);
`endif
        spi_end(1);
        check("t3_underrun_2", 32'(un[1] - un0), 32'd2);

        // 4: consumer stalled over two words -> single overrun, second word kept
        ov0 = ov[0];
        bus_a.rx_ready = 1'b0;
        spi_begin(0);
        spi_word(0, 32'h11, 8, 32'h0, 1'b0);
        spi_word(0, 32'h22, 8, 32'h0, 1'b0);
        spi_end(0);
        check("t4_rx_data",  32'(bus_a.rx_data), 32'h22);
        check("t4_rx_valid", 32'(bus_a.rx_valid), 32'd1);
        check("t4_overruns", 32'(ov[0] - ov0), 32'd1);
        exp_a.push_back(32'h22);
        bus_a.rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;

        // 5: deselect after 5 bits drops the partial word
        spi_begin(0);
        spi_word(0, 32'hFF, 5, 32'h0, 1'b0);
        spi_end(0);
        check("t5_no_partial", 32'(bus_a.rx_valid), 32'd0);
        exp_a.push_back(32'hC3);
        spi_begin(0);
        spi_word(0, 32'hC3, 8, 32'h0, 1'b0);
        spi_end(0);

        // 6: reset pulse mid-word with ssel_n held low
        spi_begin(0);
        spi_word(0, 32'h7, 3, 32'h0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        check("t6_busy",     32'(bus_a.busy), 32'd0);
        check("t6_tx_ready", 32'(bus_a.tx_ready), 32'd1);
        check("t6_rx_valid", 32'(bus_a.rx_valid), 32'd0);
        check("t6_rx_data",  32'(bus_a.rx_data), 32'd0);
        check("t6_miso",     32'(bus_a.miso), 32'd0);
        spi_word(0, 32'h99, 8, 32'h0, 1'b0);
        check("t6_no_rx_held_low", 32'(bus_a.rx_valid), 32'd0);
        check("t6_idle_held_low",  32'(bus_a.busy), 32'd0);
        spi_end(0);
        exp_a.push_back(32'h5A);
        spi_begin(0);
        spi_word(0, 32'h5A, 8, 32'h00, 1'b1);
        spi_end(0);

        // 7: 16-bit LSB-first
        push_tx(2, 32'h0001);
        exp_c.push_back(32'hBEEF);
        spi_begin(2);
        check("t7_first_miso", 32'(bus_c.miso), 32'd1);
        spi_word(2, 32'hBEEF, 16, 32'h0001, 1'b1);
        spi_end(2);

        repeat (20) @(posedge clk);
        #2;
        check("left_a", 32'(exp_a.size()), 32'd0);
        check("left_b", 32'(exp_b.size()), 32'd0);
        check("left_c", 32'(exp_c.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
